memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_if.sv | 16 +
 rtl/memory_responder.sv | 119 +++++++++++
 tb/tb_memory_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_responder_if.sv
// Initiator-side control and status of the memory responder; the shared data bus stays a plain inout.
// slave: the responder. master: the initiator that raises readM/writeM and watches ready/busy/err.
`timescale 1ns/1ps
interface memory_responder_if #(
    parameter int WORD_SIZE = 16
) ();
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;
    logic                 ready;
    logic                 busy;
    logic                 err;

    modport slave  (input readM, writeM, address, output ready, busy, err);
    modport master (output readM, writeM, address, input ready, busy, err);
endinterface

// File: rtl/memory_responder.sv
// Level-handshake memory: reads answer READ_LATENCY edges after acceptance, writes commit WRITE_LATENCY edges after.
// No backpressure: the initiator holds readM/writeM until ready, and dropping the level aborts or completes the op.
`timescale 1ns/1ps
module memory_responder #(
    parameter int WORD_SIZE     = 16,
    parameter int DEPTH         = 256,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    memory_responder_if.slave    bus,
    inout  wire  [WORD_SIZE-1:0] data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] RD_CNT = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_CNT = 4'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_DONE} state_e;

    state_e               state_q;
    logic [3:0]           cnt_q;
    logic [AW-1:0]        idx_q;
    logic [WORD_SIZE-1:0] wdat_q;
    logic [WORD_SIZE-1:0] rdat_q;
    logic                 ready_q;
    logic                 err_q;
    logic                 drive_q;
    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    // Upper address bits are deliberately ignored so addresses wrap modulo DEPTH.
    wire [AW-1:0] idx_d = bus.address[AW-1:0];
    generate
        if (AW < WORD_SIZE) begin : g_addr_hi
            wire unused_addr_hi = ^bus.address[WORD_SIZE-1:AW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            drive_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.readM && bus.writeM) begin
                        err_q <= 1'b1;
                    end else if (bus.readM) begin
                        idx_q   <= idx_d;
                        cnt_q   <= RD_CNT;
                        state_q <= RD_WAIT;
                    end else if (bus.writeM) begin
                        idx_q   <= idx_d;
                        wdat_q  <= data;
                        cnt_q   <= WR_CNT;
                        state_q <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (!bus.readM) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        rdat_q  <= mem_q[idx_q];
                        ready_q <= 1'b1;
                        drive_q <= 1'b1;
                        state_q <= RD_DRIVE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RD_DRIVE: begin
                    if (!bus.readM) begin
                        ready_q <= 1'b0;
                        drive_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                WR_WAIT: begin
                    // Dropping writeM before the commit edge abandons the write entirely.
                    if (!bus.writeM) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        mem_q[idx_q] <= wdat_q;
                        ready_q      <= 1'b1;
                        state_q      <= WR_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_DONE: begin
                    if (!bus.writeM) begin
                        ready_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    drive_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data      = drive_q ? rdat_q : {WORD_SIZE{1'bz}};
    assign bus.ready = ready_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.err   = err_q;
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: default latencies on dut_a, READ_LATENCY=1 on dut_b.
// Inputs change and outputs are sampled on the falling edge, away from the active rising edge.
`timescale 1ns/1ps
module tb_memory_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    memory_responder_if #(.WORD_SIZE(16)) ifa ();
    memory_responder_if #(.WORD_SIZE(16)) ifb ();

    wire  [15:0] data_a;
    wire  [15:0] data_b;
    logic        tb_oe_a, tb_oe_b;
    logic [15:0] tb_dat_a, tb_dat_b;

    assign data_a = tb_oe_a ? tb_dat_a : 16'bz;
    assign data_b = tb_oe_b ? tb_dat_b : 16'bz;

    memory_responder #(.WORD_SIZE(16), .DEPTH(256), .READ_LATENCY(2), .WRITE_LATENCY(2)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa),
        .data    (data_a)
    );

    memory_responder #(.WORD_SIZE(16), .DEPTH(256), .READ_LATENCY(1), .WRITE_LATENCY(2)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb),
        .data    (data_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Address/data are scrambled right after acceptance; the op must use the latched values.
    task automatic write_a(input logic [15:0] a, input logic [15:0] v, input string tag);
        ifa.writeM = 1'b1;
        ifa.address = a;
        tb_dat_a = v;
        tb_oe_a = 1'b1;
        @(negedge clk);
        chk({tag, "_acc_busy"}, 16'(ifa.busy), 16'd1);
        chk({tag, "_acc_rdy"}, 16'(ifa.ready), 16'd0);
        ifa.address = a ^ 16'h00F0;
        tb_dat_a = ~v;
        @(negedge clk);
        chk({tag, "_wait_rdy"}, 16'(ifa.ready), 16'd0);
        @(negedge clk);
        chk({tag, "_done_rdy"}, 16'(ifa.ready), 16'd1);
        chk({tag, "_done_nodrive"}, 16'(dut_a.drive_q), 16'd0);
        ifa.writeM = 1'b0;
        tb_oe_a = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_rdy"}, 16'(ifa.ready), 16'd0);
        chk({tag, "_idle_busy"}, 16'(ifa.busy), 16'd0);
    endtask

    task automatic read_a(input logic [15:0] a, input logic [15:0] exp, input string tag, input bit rel);
        ifa.readM = 1'b1;
        ifa.address = a;
        @(negedge clk);
        chk({tag, "_acc_busy"}, 16'(ifa.busy), 16'd1);
        chk({tag, "_acc_rdy"}, 16'(ifa.ready), 16'd0);
        ifa.address = a ^ 16'h00F0;
        @(negedge clk);
        chk({tag, "_wait_rdy"}, 16'(ifa.ready), 16'd0);
        chk({tag, "_wait_nodrive"}, 16'(dut_a.drive_q), 16'd0);
        @(negedge clk);
        chk({tag, "_drv_rdy"}, 16'(ifa.ready), 16'd1);
        chk({tag, "_drv_drive"}, 16'(dut_a.drive_q), 16'd1);
        chk({tag, "_data"}, data_a, exp);
        if (rel) begin
            ifa.readM = 1'b0;
            @(negedge clk);
            chk({tag, "_rel_rdy"}, 16'(ifa.ready), 16'd0);
            chk({tag, "_rel_z"}, 16'(dut_a.drive_q), 16'd0);
            chk({tag, "_rel_busy"}, 16'(ifa.busy), 16'd0);
        end
    endtask

    task automatic write_b(input logic [15:0] a, input logic [15:0] v, input string tag);
        ifb.writeM = 1'b1;
        ifb.address = a;
        tb_dat_b = v;
        tb_oe_b = 1'b1;
        repeat (3) @(negedge clk);
        chk({tag, "_done_rdy"}, 16'(ifb.ready), 16'd1);
        ifb.writeM = 1'b0;
        tb_oe_b = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_busy"}, 16'(ifb.busy), 16'd0);
    endtask

    initial begin
        // Requests held during reset must be ignored.
        reset_n = 1'b0;
        ifa.readM = 1'b1; ifa.writeM = 1'b1; ifa.address = 16'h0000;
        ifb.readM = 1'b0; ifb.writeM = 1'b0; ifb.address = 16'h0000;
        tb_oe_a = 1'b0; tb_dat_a = 16'h0000;
        tb_oe_b = 1'b0; tb_dat_b = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_busy", 16'(ifa.busy), 16'd0);
        chk("rst_rdy", 16'(ifa.ready), 16'd0);
        chk("rst_err", 16'(ifa.err), 16'd0);
        chk("rst_z", 16'(dut_a.drive_q), 16'd0);
        chk("rst_b_busy", 16'(ifb.busy), 16'd0);
        ifa.readM = 1'b0; ifa.writeM = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 16'(ifa.busy), 16'd0);

        write_a(16'h0005, 16'h1234, "w5");
        read_a(16'h0005, 16'h1234, "r5", 1'b1);

        write_a(16'h0105, 16'hBEEF, "wwrap");
        read_a(16'h0005, 16'hBEEF, "rwrap", 1'b1);

        ifa.readM = 1'b1; ifa.writeM = 1'b1; ifa.address = 16'h0005;
        @(negedge clk);
        chk("err_pulse", 16'(ifa.err), 16'd1);
        chk("err_busy", 16'(ifa.busy), 16'd0);
        chk("err_rdy", 16'(ifa.ready), 16'd0);
        ifa.readM = 1'b0; ifa.writeM = 1'b0;
        @(negedge clk);
        chk("err_clear", 16'(ifa.err), 16'd0);
        read_a(16'h0005, 16'hBEEF, "r_after_err", 1'b1);

        // Write to addr 3 abandoned one cycle into WR_WAIT.
        ifa.writeM = 1'b1; ifa.address = 16'h0003; tb_dat_a = 16'hAAAA; tb_oe_a = 1'b1;
        @(negedge clk);
        chk("wabort_busy", 16'(ifa.busy), 16'd1);
        ifa.writeM = 1'b0; tb_oe_a = 1'b0;
        @(negedge clk);
        chk("wabort_idle", 16'(ifa.busy), 16'd0);
        chk("wabort_rdy", 16'(ifa.ready), 16'd0);
        @(negedge clk);
        chk("wabort_rdy2", 16'(ifa.ready), 16'd0);
        read_a(16'h0003, 16'h0000, "r_abort", 1'b1);

        ifa.readM = 1'b1; ifa.address = 16'h0005;
        @(negedge clk);
        chk("rabort_busy", 16'(ifa.busy), 16'd1);
        ifa.readM = 1'b0;
        @(negedge clk);
        chk("rabort_idle", 16'(ifa.busy), 16'd0);
        chk("rabort_z", 16'(dut_a.drive_q), 16'd0);
        @(negedge clk);
        chk("rabort_rdy", 16'(ifa.ready), 16'd0);

        // Reset in WR_WAIT drops the pending write.
        ifa.writeM = 1'b1; ifa.address = 16'h0020; tb_dat_a = 16'h5555; tb_oe_a = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstwr_busy", 16'(ifa.busy), 16'd0);
        chk("rstwr_rdy", 16'(ifa.ready), 16'd0);
        ifa.writeM = 1'b0; tb_oe_a = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        read_a(16'h0020, 16'h0000, "r_rstwr", 1'b1);

        // Reset while data is being driven; readM stays high throughout.
        write_a(16'h0005, 16'h1234, "w5b");
        read_a(16'h0005, 16'h1234, "rdrv", 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstrd_rdy", 16'(ifa.ready), 16'd0);
        chk("rstrd_busy", 16'(ifa.busy), 16'd0);
        chk("rstrd_z", 16'(dut_a.drive_q), 16'd0);
        ifa.readM = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        read_a(16'h0005, 16'h0000, "r_clr5", 1'b1);
        read_a(16'h00FF, 16'h0000, "r_clrff", 1'b1);

        write_b(16'h0007, 16'h7777, "wb7");
        write_b(16'h0009, 16'h9999, "wb9");
        ifb.readM = 1'b1; ifb.address = 16'h0007;
        @(negedge clk);
        chk("rb_acc_rdy", 16'(ifb.ready), 16'd0);
        chk("rb_acc_busy", 16'(ifb.busy), 16'd1);
        ifb.address = 16'h0009;
        @(negedge clk);
        chk("rb_rdy", 16'(ifb.ready), 16'd1);
        chk("rb_data", data_b, 16'h7777);
        ifb.readM = 1'b0;
        @(negedge clk);
        chk("rb_rel_rdy", 16'(ifb.ready), 16'd0);
        chk("rb_rel_z", 16'(dut_b.drive_q), 16'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
